// File: rtl/fir_stream_arbiter.sv
// Packet-level round-robin arbiter that shares one fir_filter among several AXI-Stream sources.
// One packet is forwarded at a time; all sources are held off until the filter flush completes.
module fir_stream_arbiter #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned ID_W          = $clog2(NUM_SRC),
    parameter int unsigned DRAIN_TIMEOUT = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         f_axis_tdata,
    output logic                          f_axis_tvalid,
    input  logic                          f_axis_tready,
    output logic                          f_axis_tlast,
    input  logic                          fo_tvalid,
    input  logic                          fo_tlast,
    output logic [ID_W-1:0]               out_id,
    output logic                          busy,
    output logic                          pkt_done,
    output logic                          timeout_err
);
    localparam int unsigned TIMER_W = $clog2(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                pkt_done_q, pkt_done_d;
    logic                timeout_err_q, timeout_err_d;

    logic [ID_W-1:0]       cand;
    logic [ID_W-1:0]       req_idx;
    logic                  req_found;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;

    // Round-robin scan starting one past the previous winner.
    always_comb begin
        cand      = '0;
        req_idx   = '0;
        req_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = ID_W'((32'(last_grant_q) + i) % NUM_SRC);
            if (!req_found && s_axis_tvalid[cand]) begin
                req_idx   = cand;
                req_found = 1'b1;
            end
        end
    end

    // Mux of the granted source onto the filter input.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (ID_W'(k) == grant_q) begin
                sel_data  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[k];
                sel_last  = s_axis_tlast[k];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        timer_d       = timer_q;
        pkt_done_d    = 1'b0;
        timeout_err_d = 1'b0;
        s_axis_tready = '0;
        f_axis_tdata  = '0;
        f_axis_tvalid = 1'b0;
        f_axis_tlast  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d      = req_idx;
                    last_grant_d = req_idx;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                f_axis_tdata  = sel_data;
                f_axis_tvalid = sel_valid;
                f_axis_tlast  = sel_last;
                for (int unsigned k = 0; k < NUM_SRC; k++) begin
                    s_axis_tready[k] = (ID_W'(k) == grant_q) && f_axis_tready;
                end
                if (sel_valid && f_axis_tready && sel_last) begin
                    state_d = DRAIN;
                    timer_d = TIMER_W'(DRAIN_TIMEOUT - 1);
                end
            end
            DRAIN: begin
                // Filter output tlast takes priority over a simultaneous watchdog expiry.
                if (fo_tvalid && fo_tlast) begin
                    pkt_done_d = 1'b1;
                    state_d    = IDLE;
                end else if (timer_q == '0) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= ID_W'(NUM_SRC - 1);
            timer_q       <= '0;
            pkt_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            timer_q       <= timer_d;
            pkt_done_q    <= pkt_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign out_id      = grant_q;
    assign busy        = (state_q != IDLE);
    assign pkt_done    = pkt_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Self-checking bench for fir_stream_arbiter: packet-level reference model plus a simple
// filter responder that emits one output per input beat and TAPS flush beats per packet.
module tb_fir_stream_arbiter;
    localparam int unsigned DW   = 16;
    localparam int unsigned NS   = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned DT   = 32;
    localparam int unsigned TAPS = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]    f_tdata;
    logic             f_tvalid, f_tready, f_tlast;
    logic             fo_tvalid, fo_tlast;
    logic [IDW-1:0]   out_id;
    logic             busy, pkt_done, timeout_err;

    fir_stream_arbiter #(
        .DATA_WIDTH(DW), .NUM_SRC(NS), .ID_W(IDW), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .f_axis_tdata(f_tdata), .f_axis_tvalid(f_tvalid), .f_axis_tready(f_tready),
        .f_axis_tlast(f_tlast),
        .fo_tvalid(fo_tvalid), .fo_tlast(fo_tlast),
        .out_id(out_id), .busy(busy), .pkt_done(pkt_done), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source stimulus queues and model expectation queues: {last, data}.
    logic [DW:0]  drv_q [NS][$];
    logic [DW:0]  exp_q [NS][$];
    logic [IDW:0] resp_q[$];
    logic [IDW-1:0] fo_id;

    // Reference model state.
    bit m_busy, m_drain, m_first, m_exp_done, m_exp_to;
    int m_owner, m_last, m_left;

    // Stimulus controls and logs.
    int rdy_mode;
    bit bubbles, resp_en;
    int grant_log[$];
    int hs_cycles[$];
    int done_cnt, to_cnt, to_cyc, drain_cyc, fo_cnt;
    logic [NS-1:0] obs_rdy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NS-1:0] req);
        for (int i = 1; i <= int'(NS); i++) begin
            if (req[(last + i) % NS]) return (last + i) % NS;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int k = 0; k < int'(NS); k++) if (drv_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_srcs();
        logic [DW:0] b;
        for (int k = 0; k < int'(NS); k++) begin
            if (drv_q[k].size() != 0 && !(bubbles && $urandom_range(0, 3) == 0)) begin
                b = drv_q[k][0];
                s_tvalid[k] = 1'b1;
                s_tdata[k*DW +: DW] = b[DW-1:0];
                s_tlast[k] = b[DW];
            end else begin
                s_tvalid[k] = 1'b0;
                s_tdata[k*DW +: DW] = '0;
                s_tlast[k] = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int k, input int n, input logic [DW-1:0] base, input bit rnd);
        logic [DW:0] b;
        for (int i = 0; i < n; i++) begin
            b[DW-1:0] = rnd ? DW'($urandom) : base + DW'(i);
            b[DW]     = (i == n - 1);
            drv_q[k].push_back(b);
            exp_q[k].push_back(b);
        end
    endtask

    // One clock: observe at the falling edge, then update drives just after the rising edge.
    task automatic cycle();
        logic [NS-1:0] exp_rdy, pop_mask;
        logic          exp_fv;
        logic [DW:0]   b;
        logic [IDW:0]  r;
        @(negedge clk);
        cyc++;
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("pkt_done", 32'(pkt_done), 32'(m_exp_done));
        check_eq("timeout_err", 32'(timeout_err), 32'(m_exp_to));
        if (pkt_done) done_cnt++;
        if (timeout_err) begin to_cnt++; to_cyc = cyc; end
        if (m_busy) check_eq("out_id", 32'(out_id), 32'(m_owner));
        exp_rdy = '0;
        exp_fv  = 1'b0;
        if (m_busy && !m_drain) begin
            exp_fv = s_tvalid[m_owner];
            if (f_tready) exp_rdy[m_owner] = 1'b1;
        end
        obs_rdy = s_tready;
        check_eq("s_tready", 32'(s_tready), 32'(exp_rdy));
        check_eq("f_tvalid", 32'(f_tvalid), 32'(exp_fv));
        if (fo_tvalid) begin
            fo_cnt++;
            check_eq("fo_out_id", 32'(out_id), 32'(fo_id));
        end
        pop_mask = s_tvalid & s_tready;

        m_exp_done = 1'b0;
        m_exp_to   = 1'b0;
        if (!m_busy) begin
            if (s_tvalid != '0) begin
                m_owner = rr_pick(m_last, s_tvalid);
                m_last  = m_owner;
                m_busy  = 1'b1;
                m_drain = 1'b0;
                m_first = 1'b1;
            end
        end else if (!m_drain) begin
            if (exp_fv && f_tready) begin
                hs_cycles.push_back(cyc);
                if (m_first) begin grant_log.push_back(int'(out_id)); m_first = 1'b0; end
                check_eq("beat_avail", 32'(exp_q[m_owner].size() != 0), 32'd1);
                if (exp_q[m_owner].size() != 0) begin
                    b = exp_q[m_owner].pop_front();
                    check_eq("f_tdata", 32'(f_tdata), 32'(b[DW-1:0]));
                    check_eq("f_tlast", 32'(f_tlast), 32'(b[DW]));
                    resp_q.push_back({1'b0, IDW'(m_owner)});
                    if (b[DW]) begin
                        m_drain   = 1'b1;
                        m_left    = DT;
                        drain_cyc = cyc;
                        for (int t = 0; t < int'(TAPS); t++)
                            resp_q.push_back({t == int'(TAPS) - 1, IDW'(m_owner)});
                    end
                end
            end
        end else begin
            if (fo_tvalid && fo_tlast) begin
                m_exp_done = 1'b1;
                m_busy = 1'b0;
                m_drain = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_exp_to = 1'b1;
                    m_busy = 1'b0;
                    m_drain = 1'b0;
                end
            end
        end

        @(posedge clk);
        #1;
        for (int k = 0; k < int'(NS); k++)
            if (pop_mask[k] && drv_q[k].size() != 0) void'(drv_q[k].pop_front());
        fo_tvalid = 1'b0;
        fo_tlast  = 1'b0;
        if (resp_en && resp_q.size() != 0) begin
            r = resp_q.pop_front();
            fo_tvalid = 1'b1;
            fo_tlast  = r[IDW];
            fo_id     = r[IDW-1:0];
        end
        case (rdy_mode)
            1:       f_tready = ($urandom_range(0, 3) != 0);
            2:       f_tready = 1'b0;
            default: f_tready = 1'b1;
        endcase
        drive_srcs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < int'(NS); k++) begin drv_q[k].delete(); exp_q[k].delete(); end
        resp_q.delete();
        drive_srcs();
        fo_tvalid = 1'b0;
        fo_tlast  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_s_tready", 32'(s_tready), 32'd0);
        check_eq("rst_f_tvalid", 32'(f_tvalid), 32'd0);
        check_eq("rst_f_tlast", 32'(f_tlast), 32'd0);
        check_eq("rst_f_tdata", 32'(f_tdata), 32'd0);
        check_eq("rst_out_id", 32'(out_id), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pulses", 32'({pkt_done, timeout_err}), 32'd0);
        rst = 1'b0;
        m_busy = 1'b0; m_drain = 1'b0; m_first = 1'b0;
        m_exp_done = 1'b0; m_exp_to = 1'b0;
        m_last = NS - 1; m_owner = 0;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((m_busy || any_pending()) && n < budget) begin cycle(); n++; end
        check_eq("idle_within_budget", 32'(m_busy || any_pending()), 32'd0);
        cycle();
        cycle();
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_fair[3] = '{3, 1, 3};

    initial begin
        int n;
        rst = 1'b1;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        f_tready = 1'b1; fo_tvalid = 1'b0; fo_tlast = 1'b0; fo_id = '0;
        rdy_mode = 0; bubbles = 1'b0; resp_en = 1'b1;
        done_cnt = 0; to_cnt = 0; to_cyc = 0; drain_cyc = 0; fo_cnt = 0;
        do_reset();

        // Single source, three beats.
        hs_cycles.delete(); fo_cnt = 0; done_cnt = 0;
        load_pkt(0, 3, 16'd1, 1'b0);
        drive_srcs();
        run_idle(100);
        check_eq("t1_beats", 32'(hs_cycles.size()), 32'd3);
        if (hs_cycles.size() == 3) begin
            check_eq("t1_consec_a", 32'(hs_cycles[1] - hs_cycles[0]), 32'd1);
            check_eq("t1_consec_b", 32'(hs_cycles[2] - hs_cycles[1]), 32'd1);
        end
        check_eq("t1_fo_beats", 32'(fo_cnt), 32'd11);
        check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t1_busy_low", 32'(busy), 32'd0);

        // Round robin across all sources.
        do_reset();
        grant_log.delete();
        load_pkt(0, 2, 16'h100, 1'b0);
        load_pkt(0, 2, 16'h110, 1'b0);
        load_pkt(1, 2, 16'h200, 1'b0);
        load_pkt(2, 2, 16'h300, 1'b0);
        load_pkt(3, 2, 16'h400, 1'b0);
        drive_srcs();
        run_idle(400);
        check_eq("rr_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check_eq("rr_order", 32'(grant_log[i]), 32'(exp_rr[i]));

        // Fairness when only sources 1 and 3 request, after source 1 last won.
        do_reset();
        load_pkt(1, 1, 16'h500, 1'b0);
        drive_srcs();
        run_idle(100);
        grant_log.delete();
        load_pkt(1, 2, 16'h510, 1'b0);
        load_pkt(3, 2, 16'h530, 1'b0);
        load_pkt(3, 1, 16'h540, 1'b0);
        drive_srcs();
        run_idle(300);
        check_eq("fair_count", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++)
            check_eq("fair_order", 32'(grant_log[i]), 32'(exp_fair[i]));

        // Backpressure mid-packet.
        hs_cycles.delete();
        load_pkt(0, 4, 16'h600, 1'b0);
        drive_srcs();
        n = 0;
        while (hs_cycles.size() < 1 && n < 20) begin cycle(); n++; end
        f_tready = 1'b0;
        rdy_mode = 2;
        cycle();
        check_eq("bp_rdy_low_a", 32'(obs_rdy), 32'd0);
        rdy_mode = 0;
        cycle();
        check_eq("bp_rdy_low_b", 32'(obs_rdy), 32'd0);
        run_idle(100);
        check_eq("bp_beats", 32'(hs_cycles.size()), 32'd4);

        // Drain watchdog with no filter output.
        resp_en = 1'b0; to_cnt = 0; done_cnt = 0; to_cyc = 0;
        grant_log.delete();
        load_pkt(1, 2, 16'h700, 1'b0);
        load_pkt(2, 2, 16'h800, 1'b0);
        drive_srcs();
        n = 0;
        while (to_cnt == 0 && n < 100) begin cycle(); n++; end
        check_eq("wd_to_cnt", 32'(to_cnt), 32'd1);
        check_eq("wd_no_done", 32'(done_cnt), 32'd0);
        check_eq("wd_latency", 32'(to_cyc - drain_cyc - 1), 32'(DT));
        resp_q.delete();
        resp_en = 1'b1;
        run_idle(200);
        check_eq("wd_next_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) check_eq("wd_next_src", 32'(grant_log[1]), 32'd2);

        // Reset in the middle of a packet.
        hs_cycles.delete();
        load_pkt(0, 5, 16'h900, 1'b0);
        drive_srcs();
        n = 0;
        while (hs_cycles.size() < 2 && n < 20) begin cycle(); n++; end
        do_reset();
        grant_log.delete();
        load_pkt(2, 3, 16'hA00, 1'b0);
        drive_srcs();
        run_idle(100);
        check_eq("rst_regrant_count", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() == 1) check_eq("rst_regrant_src", 32'(grant_log[0]), 32'd2);

        // Randomized traffic with valid bubbles and random filter backpressure.
        bubbles = 1'b1;
        rdy_mode = 1;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < int'(NS); k++)
                if (drv_q[k].size() == 0 && $urandom_range(0, 1) == 1)
                    load_pkt(k, int'($urandom_range(1, 5)), 16'h0, 1'b1);
            n = int'($urandom_range(5, 30));
            for (int c = 0; c < n; c++) cycle();
        end
        run_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
